// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: run sequencer for the pipelined RISC-V Datapath.
// It holds the core in reset for a programmable number of cycles, runs it
// against a cycle budget, and watches the data-memory write port for a
// tohost-style store that ends the program. Cycle and retire counts plus
// the pass/fail/timeout verdict stay readable until the next start.

module sim_run_ctrl #(
  parameter int                RESET_CYCLES = 2,
  parameter int                MAX_CYCLES   = 20,
  parameter int                CNT_W        = 32,
  parameter int                ADDR_W       = 32,
  parameter int                DATA_W       = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR  = ADDR_W'(32'h0000_1000)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              retire_valid,
  output logic              core_reset,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [DATA_W-1:0] exit_code,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  retire_count
);

  // The hold counter counts down from RESET_CYCLES-1 to 0, so it only needs
  // enough bits for RESET_CYCLES-1 (at least one bit).
  localparam int                HOLD_W         = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD      = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LAST_RUN_CYCLE = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE        = CNT_W'(1);
  localparam logic [DATA_W-1:0] EXIT_PASS      = DATA_W'(1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RESET_HOLD = 2'd1,
    RUN        = 2'd2,
    DONE       = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] holdCnt_q, holdCnt_d;
  logic              coreReset_q, coreReset_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic [DATA_W-1:0] exitCode_q, exitCode_d;
  logic [CNT_W-1:0]  cycleCount_q, cycleCount_d;
  logic [CNT_W-1:0]  retireCount_q, retireCount_d;

  logic haltHit;
  logic budgetOut;
  logic beginRun;

  // Saturating increment so a very long run pins the counter at all-ones
  // instead of wrapping back to a small, misleading value.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
    logic [CNT_W-1:0] result;
    if (&value) begin
      result = value;
    end else begin
      result = value + CNT_ONE;
    end
    return result;
  endfunction

  // A store to the tohost address only counts while the core is actually
  // running; stores seen during reset hold, idle or done are stale traffic.
  assign haltHit   = (state_q == RUN) && mem_we && (mem_addr == TOHOST_ADDR);

  // The budget runs out on the cycle whose count, including itself, reaches
  // MAX_CYCLES; a halt on that same cycle still wins over the timeout.
  assign budgetOut = (state_q == RUN) && (cycleCount_q == LAST_RUN_CYCLE);

  // A new run may be launched from idle or as a rerun once a verdict exists.
  assign beginRun  = start && ((state_q == IDLE) || (state_q == DONE));

  // Next-state and next-output logic; every register defaults to holding.
  always_comb begin
    state_d       = state_q;
    holdCnt_d     = holdCnt_q;
    coreReset_d   = coreReset_q;
    running_d     = running_q;
    done_d        = done_q;
    pass_d        = pass_q;
    timeout_d     = timeout_q;
    exitCode_d    = exitCode_q;
    cycleCount_d  = cycleCount_q;
    retireCount_d = retireCount_q;

    unique case (state_q)
      IDLE: begin
        coreReset_d = 1'b1;
        running_d   = 1'b0;
        if (beginRun) begin
          state_d       = RESET_HOLD;
          holdCnt_d     = HOLD_LOAD;
          done_d        = 1'b0;
          pass_d        = 1'b0;
          timeout_d     = 1'b0;
          exitCode_d    = '0;
          cycleCount_d  = '0;
          retireCount_d = '0;
        end
      end

      RESET_HOLD: begin
        coreReset_d = 1'b1;
        running_d   = 1'b0;
        if (holdCnt_q == '0) begin
          state_d     = RUN;
          coreReset_d = 1'b0;
          running_d   = 1'b1;
        end else begin
          holdCnt_d = holdCnt_q - HOLD_W'(1);
        end
      end

      RUN: begin
        coreReset_d  = 1'b0;
        running_d    = 1'b1;
        cycleCount_d = satInc(cycleCount_q);
        if (retire_valid) begin
          retireCount_d = satInc(retireCount_q);
        end
        if (haltHit) begin
          state_d     = DONE;
          exitCode_d  = mem_wdata;
          pass_d      = (mem_wdata == EXIT_PASS);
          timeout_d   = 1'b0;
          done_d      = 1'b1;
          running_d   = 1'b0;
          coreReset_d = 1'b1;
        end else if (budgetOut) begin
          state_d     = DONE;
          timeout_d   = 1'b1;
          pass_d      = 1'b0;
          done_d      = 1'b1;
          running_d   = 1'b0;
          coreReset_d = 1'b1;
        end
      end

      DONE: begin
        coreReset_d = 1'b1;
        running_d   = 1'b0;
        if (beginRun) begin
          state_d       = RESET_HOLD;
          holdCnt_d     = HOLD_LOAD;
          done_d        = 1'b0;
          pass_d        = 1'b0;
          timeout_d     = 1'b0;
          exitCode_d    = '0;
          cycleCount_d  = '0;
          retireCount_d = '0;
        end
      end

      default: begin
        state_d     = IDLE;
        coreReset_d = 1'b1;
        running_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; a low reset forces the idle, core-in-reset
  // picture on the next edge no matter where the sequencer was.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      holdCnt_q     <= '0;
      coreReset_q   <= 1'b1;
      running_q     <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
      exitCode_q    <= '0;
      cycleCount_q  <= '0;
      retireCount_q <= '0;
    end else begin
      state_q       <= state_d;
      holdCnt_q     <= holdCnt_d;
      coreReset_q   <= coreReset_d;
      running_q     <= running_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      timeout_q     <= timeout_d;
      exitCode_q    <= exitCode_d;
      cycleCount_q  <= cycleCount_d;
      retireCount_q <= retireCount_d;
    end
  end

  assign core_reset   = coreReset_q;
  assign running      = running_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign timeout      = timeout_q;
  assign exit_code    = exitCode_q;
  assign cycle_count  = cycleCount_q;
  assign retire_count = retireCount_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// tb_sim_run_ctrl: self-checking bench for sim_run_ctrl. Each scenario task
// drives a run and predicts the outcome from the run rules: reset hold length,
// which run cycle ends the program, and how many retire pulses fell inside it.

module tb_sim_run_ctrl;

  localparam int          RC     = 2;
  localparam int          MC     = 20;
  localparam int          CW     = 32;
  localparam int          AW     = 32;
  localparam int          DW     = 32;
  localparam logic [31:0] TOHOST = 32'h0000_1000;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          retire_valid;
  logic          core_reset;
  logic          running;
  logic          done;
  logic          pass;
  logic          timeout;
  logic [DW-1:0] exit_code;
  logic [CW-1:0] cycle_count;
  logic [CW-1:0] retire_count;

  int checks = 0;
  int errors = 0;

  sim_run_ctrl #(
    .RESET_CYCLES(RC),
    .MAX_CYCLES  (MC),
    .CNT_W       (CW),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TOHOST_ADDR (TOHOST)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .retire_valid(retire_valid),
    .core_reset  (core_reset),
    .running     (running),
    .done        (done),
    .pass        (pass),
    .timeout     (timeout),
    .exit_code   (exit_code),
    .cycle_count (cycle_count),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just past it before looking at outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic we, input logic [31:0] ad,
                               input logic [31:0] wd, input logic rv);
    start        = st;
    mem_we       = we;
    mem_addr     = ad;
    mem_wdata    = wd;
    retire_valid = rv;
  endtask

  function automatic logic [31:0] otherAddr();
    logic [31:0] a;
    a = $urandom;
    if (a == TOHOST) a = 32'h0000_0FFC;
    return a;
  endfunction

  // One complete run from IDLE or DONE. haltCycle is the 1-based run cycle
  // carrying the tohost store; values outside 1..MC mean the program never halts.
  task automatic runProgram(input string name, input int haltCycle, input logic [31:0] haltData,
                            input bit allRetire, input bit noisy);
    bit          halted;
    int          finalCycle;
    int          retired;
    logic        rv;
    logic        we;
    logic [31:0] ad;
    logic [4:0]  expStat;
    logic [31:0] expExit;

    halted     = (haltCycle >= 1) && (haltCycle <= MC);
    finalCycle = halted ? haltCycle : MC;
    retired    = 0;

    // Start edge: everything clears, core stays in reset. A store to tohost
    // on this same edge happens outside RUN and must be ignored.
    applyStimulus(1'b1, noisy, TOHOST, 32'h1, noisy);
    tick();
    if ({core_reset, running, done, pass, timeout} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL %s start_status: got %b expected %b", name,
               {core_reset, running, done, pass, timeout}, 5'b10000);
    end
    checks++;
    if (cycle_count !== 0 || retire_count !== 0 || exit_code !== 0) begin
      errors++;
      $display("[TB] FAIL %s start_clear: got cyc=%0d ret=%0d exit=%0h expected 0/0/0",
               name, cycle_count, retire_count, exit_code);
    end
    checks++;

    // Reset hold: core_reset stays high for RC cycles counted from the start edge.
    for (int j = 1; j <= RC; j++) begin
      if (noisy) applyStimulus(1'($urandom_range(0, 1)), 1'b1,
                               (j % 2 == 1) ? TOHOST : 32'h0000_0FFC, 32'h1, 1'b1);
      else       applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      tick();
      expStat = (j < RC) ? 5'b10000 : 5'b01000;
      if ({core_reset, running, done, pass, timeout} !== expStat) begin
        errors++;
        $display("[TB] FAIL %s hold_status[%0d]: got %b expected %b", name, j,
                 {core_reset, running, done, pass, timeout}, expStat);
      end
      checks++;
      if (cycle_count !== 0 || retire_count !== 0 || exit_code !== 0) begin
        errors++;
        $display("[TB] FAIL %s hold_counts[%0d]: got cyc=%0d ret=%0d exit=%0h expected 0/0/0",
                 name, j, cycle_count, retire_count, exit_code);
      end
      checks++;
    end

    // Run cycles.
    for (int c = 1; c <= finalCycle; c++) begin
      rv = allRetire ? 1'b1 : 1'($urandom_range(0, 1));
      if (c == haltCycle) begin
        applyStimulus(noisy ? 1'($urandom_range(0, 1)) : 1'b0, 1'b1, TOHOST, haltData, rv);
      end else if (noisy) begin
        we = 1'($urandom_range(0, 1));
        ad = otherAddr();
        if (!we && ($urandom_range(0, 1) == 1)) ad = TOHOST;
        applyStimulus(1'($urandom_range(0, 4) == 0), we, ad, $urandom, rv);
      end else begin
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, rv);
      end
      tick();
      if (rv) retired++;
      if (c < finalCycle) begin
        expStat = 5'b01000;
        expExit = 32'h0;
      end else begin
        expStat = {1'b1, 1'b0, 1'b1, halted && (haltData == 32'h1), !halted};
        expExit = halted ? haltData : 32'h0;
      end
      if ({core_reset, running, done, pass, timeout} !== expStat) begin
        errors++;
        $display("[TB] FAIL %s run_status[%0d]: got %b expected %b", name, c,
                 {core_reset, running, done, pass, timeout}, expStat);
      end
      checks++;
      if (cycle_count !== c || retire_count !== retired || exit_code !== expExit) begin
        errors++;
        $display("[TB] FAIL %s run_counts[%0d]: got cyc=%0d ret=%0d exit=%0h expected %0d/%0d/%0h",
                 name, c, cycle_count, retire_count, exit_code, c, retired, expExit);
      end
      checks++;
    end

    // DONE holds every result while stray stores and retires keep arriving.
    expStat = {1'b1, 1'b0, 1'b1, halted && (haltData == 32'h1), !halted};
    expExit = halted ? haltData : 32'h0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, TOHOST, $urandom, 1'b1);
      tick();
      if ({core_reset, running, done, pass, timeout} !== expStat ||
          cycle_count !== finalCycle || retire_count !== retired || exit_code !== expExit) begin
        errors++;
        $display("[TB] FAIL %s done_hold[%0d]: got %b cyc=%0d ret=%0d exit=%0h expected %b %0d/%0d/%0h",
                 name, k, {core_reset, running, done, pass, timeout}, cycle_count, retire_count,
                 exit_code, expStat, finalCycle, retired, expExit);
      end
      checks++;
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, TOHOST, 32'h1, 1'b1);
      tick();
    end
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), (i % 2 == 0) ? TOHOST : otherAddr(),
                    $urandom, 1'($urandom_range(0, 1)));
      tick();
      if ({core_reset, running, done, pass, timeout} !== 5'b10000 ||
          cycle_count !== 0 || retire_count !== 0 || exit_code !== 0) begin
        errors++;
        $display("[TB] FAIL reset_idle[%0d]: got %b cyc=%0d ret=%0d exit=%0h expected 10000 0/0/0",
                 i, {core_reset, running, done, pass, timeout}, cycle_count, retire_count, exit_code);
      end
      checks++;
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_halt_pass();
    runProgram("halt_pass", 5, 32'h1, 1'b1, 1'b0);
  endtask

  task automatic test_timeout();
    runProgram("timeout", 0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_halt_final_cycle();
    runProgram("halt_final", MC, 32'h2A, 1'b0, 1'b0);
  endtask

  task automatic test_ignored_traffic();
    runProgram("ignored_traffic", 9, 32'h1, 1'b0, 1'b1);
    runProgram("halt_first", 1, 32'h7, 1'b1, 1'b1);
  endtask

  task automatic test_reset_midrun();
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    for (int j = 1; j <= RC; j++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      tick();
    end
    for (int c = 1; c <= 2; c++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      tick();
      if (running !== 1'b1 || cycle_count !== c || retire_count !== c) begin
        errors++;
        $display("[TB] FAIL midrun_pre[%0d]: got run=%b cyc=%0d ret=%0d expected 1 %0d/%0d",
                 c, running, cycle_count, retire_count, c, c);
      end
      checks++;
    end
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, TOHOST, 32'h1, 1'b1);
    tick();
    reset = 1'b1;
    if ({core_reset, running, done, pass, timeout} !== 5'b10000 ||
        cycle_count !== 0 || retire_count !== 0 || exit_code !== 0) begin
      errors++;
      $display("[TB] FAIL midrun_reset: got %b cyc=%0d ret=%0d exit=%0h expected 10000 0/0/0",
               {core_reset, running, done, pass, timeout}, cycle_count, retire_count, exit_code);
    end
    checks++;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    if ({core_reset, running, done} !== 3'b100 || cycle_count !== 0) begin
      errors++;
      $display("[TB] FAIL midrun_idle: got %b cyc=%0d expected 100 0",
               {core_reset, running, done}, cycle_count);
    end
    checks++;
    runProgram("after_reset", 5, 32'h1, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    runProgram("rerun_a", 5, 32'h1, 1'b1, 1'b0);
    runProgram("rerun_b", 5, 32'h1, 1'b1, 1'b0);
  endtask

  task automatic test_random_runs();
    int          hc;
    logic [31:0] wd;
    for (int n = 0; n < 8; n++) begin
      hc = $urandom_range(0, MC + 3);
      wd = ($urandom_range(0, 2) == 0) ? 32'h1 : $urandom;
      runProgram($sformatf("random%0d", n), hc, wd, 1'b0, 1'b1);
    end
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    test_reset();
    test_halt_pass();
    test_timeout();
    test_halt_final_cycle();
    test_ignored_traffic();
    test_reset_midrun();
    test_back_to_back();
    test_random_runs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
